// File: rtl/gpr_wb_pkg.sv
// Shared defaults and types for the GPR writeback queue.
package gpr_wb_pkg;

    localparam int WB_DEPTH = 4;
    localparam int WB_DW    = 32;
    localparam int WB_AW    = 5;

    typedef struct packed {
        logic [WB_AW-1:0] wreg;
        logic [WB_DW-1:0] data;
    } wb_entry_t;

    localparam logic [WB_AW-1:0] REG_ZERO = '0;

endpackage

// File: rtl/gpr_wb_match.sv
// Youngest-match search over the pending writeback entries, oldest to youngest
// from head; a later match overrides an earlier one.
module gpr_wb_match
    import gpr_wb_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH,
    parameter int DW    = WB_DW,
    parameter int AW    = WB_AW,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic [AW-1:0] regs  [DEPTH],
    input  logic [DW-1:0] datas [DEPTH],
    input  logic [PW-1:0] head,
    input  logic [CW-1:0] count,
    input  logic [AW-1:0] look,
    output logic          hit,
    output logic [DW-1:0] hit_data
);

    logic [PW-1:0] idx;

    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        idx      = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            if ((CW'(i) < count) && (regs[idx] == look) && (look != AW'(REG_ZERO))) begin
                hit      = 1'b1;
                hit_data = datas[idx];
            end
        end
    end

endmodule

// File: rtl/gpr_wb_queue.sv
// In-order writeback FIFO draining one write per cycle into the GPR write port.
// Bypass lookup is built only when GPR_WB_BYPASS_EN is defined.
module gpr_wb_queue
    import gpr_wb_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH,
    parameter int DW    = WB_DW,
    parameter int AW    = WB_AW
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [AW-1:0]          req_reg,
    input  logic [DW-1:0]          req_data,
    input  logic                   flush,
    output logic                   gpr_we,
    output logic [AW-1:0]          gpr_writereg,
    output logic [DW-1:0]          gpr_writedata,
    input  logic [AW-1:0]          look_reg1,
    input  logic [AW-1:0]          look_reg2,
    output logic                   hit1,
    output logic                   hit2,
    output logic [DW-1:0]          hit_data1,
    output logic [DW-1:0]          hit_data2,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] mem_reg  [DEPTH];
    logic [DW-1:0] mem_data [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] occ;
    logic          push;
    logic          pop;

    assign empty     = (occ == '0);
    assign full      = (occ == CW'(DEPTH));
    assign req_ready = !full;
    assign count     = occ;

    // Register-0 requests complete the handshake but are never stored.
    assign push = req_valid && req_ready && !flush && (req_reg != AW'(REG_ZERO));
    assign pop  = !empty;

    assign gpr_we        = pop;
    assign gpr_writereg  = empty ? '0 : mem_reg[head];
    assign gpr_writedata = empty ? '0 : mem_data[head];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head <= '0;
            tail <= '0;
            occ  <= '0;
        end else if (flush) begin
            head <= '0;
            tail <= '0;
            occ  <= '0;
        end else begin
            if (push) tail <= tail + PW'(1);
            if (pop)  head <= head + PW'(1);
            case ({push, pop})
                2'b10:   occ <= occ + CW'(1);
                2'b01:   occ <= occ - CW'(1);
                default: occ <= occ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_reg[tail]  <= req_reg;
            mem_data[tail] <= req_data;
        end
    end

`ifdef GPR_WB_BYPASS_EN
    gpr_wb_match #(
        .DEPTH (DEPTH),
        .DW    (DW),
        .AW    (AW)
    ) u_match1 (
        .regs     (mem_reg),
        .datas    (mem_data),
        .head     (head),
        .count    (occ),
        .look     (look_reg1),
        .hit      (hit1),
        .hit_data (hit_data1)
    );

    gpr_wb_match #(
        .DEPTH (DEPTH),
        .DW    (DW),
        .AW    (AW)
    ) u_match2 (
        .regs     (mem_reg),
        .datas    (mem_data),
        .head     (head),
        .count    (occ),
        .look     (look_reg2),
        .hit      (hit2),
        .hit_data (hit_data2)
    );
`else
    logic unused_look;
    assign unused_look = ^{look_reg1, look_reg2};
    assign hit1      = 1'b0;
    assign hit2      = 1'b0;
    assign hit_data1 = '0;
    assign hit_data2 = '0;
`endif

endmodule

// File: tb/tb_gpr_wb_queue.sv
// Scoreboard bench for gpr_wb_queue: stimulus pushes expected writes, a negedge
// monitor pops and compares them along with status and bypass outputs.
`timescale 1ns/1ps
module tb_gpr_wb_queue;
    import gpr_wb_pkg::*;

    localparam int DEPTH = 4;
    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [AW-1:0] req_reg = '0;
    logic [DW-1:0] req_data = '0;
    logic          flush = 1'b0;
    logic          gpr_we;
    logic [AW-1:0] gpr_writereg;
    logic [DW-1:0] gpr_writedata;
    logic [AW-1:0] look_reg1 = '0;
    logic [AW-1:0] look_reg2 = '0;
    logic          hit1, hit2;
    logic [DW-1:0] hit_data1, hit_data2;
    logic [CW-1:0] count;
    logic          empty, full;

    wb_entry_t expq[$];
    int n_checks = 0;
    int n_pass   = 0;

    gpr_wb_queue #(
        .DEPTH (DEPTH),
        .DW    (DW),
        .AW    (AW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_reg       (req_reg),
        .req_data      (req_data),
        .flush         (flush),
        .gpr_we        (gpr_we),
        .gpr_writereg  (gpr_writereg),
        .gpr_writedata (gpr_writedata),
        .look_reg1     (look_reg1),
        .look_reg2     (look_reg2),
        .hit1          (hit1),
        .hit2          (hit2),
        .hit_data1     (hit_data1),
        .hit_data2     (hit_data2),
        .count         (count),
        .empty         (empty),
        .full          (full)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference bypass: scan pending writes oldest to youngest, keep the last match.
    function automatic void lookup(input logic [AW-1:0] look, output logic h, output logic [DW-1:0] d);
        h = 1'b0;
        d = '0;
        if (look != '0)
            foreach (expq[i])
                if (expq[i].wreg == look) begin
                    h = 1'b1;
                    d = expq[i].data;
                end
`ifndef GPR_WB_BYPASS_EN
        h = 1'b0;
        d = '0;
`endif
    endfunction

    always @(negedge clk) begin
        logic          eh1, eh2;
        logic [DW-1:0] ed1, ed2;
        int            sz;
        if (rst_n) begin
            sz = expq.size();
            check("count",     64'(count),     64'(sz));
            check("empty",     64'(empty),     64'(sz == 0));
            check("full",      64'(full),      64'(sz == DEPTH));
            check("req_ready", 64'(req_ready), 64'(sz < DEPTH));
            check("gpr_we",    64'(gpr_we),    64'(sz != 0));
            lookup(look_reg1, eh1, ed1);
            lookup(look_reg2, eh2, ed2);
            check("hit1",      64'(hit1),      64'(eh1));
            check("hit_data1", 64'(hit_data1), 64'(ed1));
            check("hit2",      64'(hit2),      64'(eh2));
            check("hit_data2", 64'(hit_data2), 64'(ed2));
            if (sz != 0) begin
                check("writereg",  64'(gpr_writereg),  64'(expq[0].wreg));
                check("writedata", 64'(gpr_writedata), 64'(expq[0].data));
                void'(expq.pop_front());
            end
        end
    end

    task automatic check_reset(input string tag);
        check({tag, " count"},     64'(count),         64'(0));
        check({tag, " empty"},     64'(empty),         64'(1));
        check({tag, " full"},      64'(full),          64'(0));
        check({tag, " req_ready"}, 64'(req_ready),     64'(1));
        check({tag, " gpr_we"},    64'(gpr_we),        64'(0));
        check({tag, " writereg"},  64'(gpr_writereg),  64'(0));
        check({tag, " writedata"}, 64'(gpr_writedata), 64'(0));
        check({tag, " hit1"},      64'(hit1),          64'(0));
        check({tag, " hit2"},      64'(hit2),          64'(0));
        check({tag, " hit_data1"}, 64'(hit_data1),     64'(0));
        check({tag, " hit_data2"}, 64'(hit_data2),     64'(0));
    endtask

    // One clock cycle: drive after the edge, record the expected effect after the monitor.
    task automatic cycle(input logic v, input logic [AW-1:0] r, input logic [DW-1:0] d,
                         input logic f, input logic [AW-1:0] l1, input logic [AW-1:0] l2);
        int occ;
        @(posedge clk);
        #1;
        req_valid = v;
        req_reg   = r;
        req_data  = d;
        flush     = f;
        look_reg1 = l1;
        look_reg2 = l2;
        occ = expq.size();
        #6;
        if (f) expq.delete();
        else if (v && (occ < DEPTH) && (r != '0)) expq.push_back('{wreg: r, data: d});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    task automatic reset_mid();
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        flush     = 1'b0;
        check("pre-reset count", 64'(count), 64'(expq.size()));
        #1 rst_n = 1'b0;
        #1 check_reset("async");
        expq.delete();
        #5 rst_n = 1'b1;
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #2 check_reset("por");
        #1 rst_n = 1'b1;

        idle(1);
        cycle(1'b1, 5'd8, 32'h1234_5678, 1'b0, 5'd8, 5'd0);
        idle(2);

        for (int i = 0; i < 5; i++)
            cycle(1'b1, 5'(10 + i), $urandom, 1'b0, 5'(10 + i), 5'(9 + i));
        idle(2);

        cycle(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0, 5'd0);
        idle(2);

        cycle(1'b1, 5'd3, 32'hA, 1'b0, 5'd3, 5'd0);
        cycle(1'b1, 5'd3, 32'hB, 1'b0, 5'd3, 5'd0);
        cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd3, 5'd0);
        idle(1);

        cycle(1'b1, 5'd7, 32'h1, 1'b0, 5'd7, 5'd0);
        cycle(1'b1, 5'd9, 32'h2, 1'b1, 5'd9, 5'd7);
        idle(2);

        cycle(1'b1, 5'd12, 32'hC0DE_0012, 1'b0, 5'd12, 5'd0);
        reset_mid();
        idle(3);

        for (int i = 0; i < 400; i++)
            cycle($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom,
                  $urandom_range(0, 15) == 0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        idle(3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
